// File: rtl/wash_program_sequencer_pkg.sv
// wash_pkg: shared state encoding, motor speed codes and state classification for the wash sequencer.
package wash_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_WASH, S_DRAIN, S_RFILL, S_RINSE, S_RDRAIN,
        S_SPIN, S_DRY, S_DONE, S_PAUSED, S_ABORT, S_FAULT
    } state_t;

    localparam logic [1:0] SPD_OFF  = 2'd0;
    localparam logic [1:0] SPD_LOW  = 2'd1;
    localparam logic [1:0] SPD_MED  = 2'd2;
    localparam logic [1:0] SPD_HIGH = 2'd3;

    function automatic logic is_run(input state_t s);
        return s inside {S_FILL, S_WASH, S_DRAIN, S_RFILL, S_RINSE, S_RDRAIN, S_SPIN, S_DRY};
    endfunction
endpackage

// File: rtl/wash_program_sequencer_phase_timer.sv
// phase_timer: loadable down-counter holding the remaining cycles of the current phase.
module phase_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               en_i,
    input  logic [TIMER_W-1:0] val_i,
    output logic [TIMER_W-1:0] count_o,
    output logic               last_o
);
    assign last_o = count_o == TIMER_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_o <= '0;
        else if (load_i) count_o <= val_i;
        else if (en_i && count_o != '0) count_o <= count_o - 1'b1;
    end
endmodule

// File: rtl/wash_program_sequencer.sv
// wash_program_sequencer: washing-machine program controller sequencing fill/wash/rinse/spin/dry
// with pause, drain-on-stop abort and fault handling.
module wash_program_sequencer
    import wash_pkg::*;
#(
    parameter int TIMER_W      = 16,
    parameter int WASH_TICKS   = 200,
    parameter int RINSE_TICKS  = 100,
    parameter int SPIN_TICKS   = 150,
    parameter int DRY_TICKS    = 300,
    parameter int RINSE_PASSES = 2,
    parameter int FILL_TIMEOUT = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               doorclosed,
    input  logic               detergentfilled,
    input  logic               water_full,
    input  logic               water_empty,
    input  logic               washOnly,
    input  logic               dry,
    input  logic [1:0]         waterTemp,
    input  logic [1:0]         spinSpeed,
    output logic               doorLock,
    output logic               fill_value_on,
    output logic               drain_value_on,
    output logic               soap_value_on,
    output logic               motorStart,
    output logic [1:0]         heater_on,
    output logic [1:0]         motor_speed,
    output logic [3:0]         state,
    output logic [2:0]         rinse_count,
    output logic [TIMER_W-1:0] timer,
    output logic               done,
    output logic               alarm
);
    state_t state_q, state_d, ret_q;
    logic [2:0] rinse_q;
    logic wash_only_q, dry_q;
    logic [1:0] temp_q, spd_q, motor_d;
    logic accept, reject, rinse_inc, last, load, en, run, fill_st;
    logic [TIMER_W-1:0] load_val;

    assign run = is_run(state_q);
    assign fill_st = state_q inside {S_FILL, S_RFILL};
    assign state = state_q;
    assign rinse_count = rinse_q;

    always_comb begin
        state_d = state_q;
        accept = 1'b0;
        reject = 1'b0;
        rinse_inc = 1'b0;
        if (stop && state_q != S_ABORT) state_d = (run || state_q == S_PAUSED) ? S_ABORT : S_IDLE;
        else if (!doorclosed && (run || state_q == S_PAUSED)) state_d = S_FAULT;
        else if (fill_st && last && !water_full) state_d = S_FAULT;
        else if (pause && run) state_d = S_PAUSED;
        else begin
            case (state_q)
                S_IDLE: begin
                    accept = start && doorclosed && detergentfilled;
                    reject = start && !accept;
                    state_d = accept ? S_FILL : S_IDLE;
                end
                S_FILL:   state_d = water_full ? S_WASH : S_FILL;
                S_WASH:   state_d = last ? S_DRAIN : S_WASH;
                S_DRAIN:  state_d = !water_empty ? S_DRAIN : wash_only_q ? S_DONE : S_RFILL;
                S_RFILL:  state_d = water_full ? S_RINSE : S_RFILL;
                S_RINSE:  state_d = last ? S_RDRAIN : S_RINSE;
                S_RDRAIN: begin
                    rinse_inc = water_empty;
                    state_d = !water_empty ? S_RDRAIN :
                              (rinse_q + 3'd1 == 3'(RINSE_PASSES)) ? S_SPIN : S_RFILL;
                end
                S_SPIN:   state_d = !last ? S_SPIN : dry_q ? S_DRY : S_DONE;
                S_DRY:    state_d = last ? S_DONE : S_DRY;
                S_DONE:   state_d = S_IDLE;
                S_PAUSED: state_d = pause ? S_PAUSED : ret_q;
                S_ABORT:  state_d = water_empty ? S_IDLE : S_ABORT;
                default:  state_d = state_q;
            endcase
        end
    end

    // Entering or leaving PAUSED keeps the held count; every other phase change reloads it.
    assign load = state_d != state_q && state_d != S_PAUSED && !(state_q == S_PAUSED && state_d == ret_q);
    assign en = state_d == state_q && state_q != S_PAUSED;
    assign load_val = (state_d == S_WASH)  ? TIMER_W'(WASH_TICKS)  :
                      (state_d == S_RINSE) ? TIMER_W'(RINSE_TICKS) :
                      (state_d == S_SPIN)  ? TIMER_W'(SPIN_TICKS)  :
                      (state_d == S_DRY)   ? TIMER_W'(DRY_TICKS)   :
                      (state_d inside {S_FILL, S_RFILL}) ? TIMER_W'(FILL_TIMEOUT) : '0;
    assign motor_d = (state_d inside {S_WASH, S_RINSE, S_DRY}) ? SPD_LOW :
                     (state_d == S_SPIN) ? ((spd_q == SPD_OFF) ? SPD_LOW : spd_q) : SPD_OFF;

    phase_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .en_i    (en),
        .val_i   (load_val),
        .count_o (timer),
        .last_o  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ret_q <= S_IDLE;
            rinse_q <= '0;
            wash_only_q <= 1'b0;
            dry_q <= 1'b0;
            temp_q <= '0;
            spd_q <= '0;
            doorLock <= 1'b0;
            fill_value_on <= 1'b0;
            drain_value_on <= 1'b0;
            soap_value_on <= 1'b0;
            motorStart <= 1'b0;
            heater_on <= '0;
            motor_speed <= '0;
            done <= 1'b0;
            alarm <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q <= (state_d == S_PAUSED && state_q != S_PAUSED) ? state_q : ret_q;
            if (accept) begin
                wash_only_q <= washOnly;
                dry_q <= dry;
                temp_q <= waterTemp;
                spd_q <= spinSpeed;
                rinse_q <= '0;
            end else if (rinse_inc) rinse_q <= rinse_q + 3'd1;
            doorLock <= !(state_d inside {S_IDLE, S_DONE, S_FAULT});
            fill_value_on <= state_d inside {S_FILL, S_RFILL};
            drain_value_on <= state_d inside {S_DRAIN, S_RDRAIN, S_ABORT, S_SPIN};
            soap_value_on <= state_d == S_FILL;
            heater_on <= (state_d == S_WASH) ? temp_q : 2'd0;
            motor_speed <= motor_d;
            motorStart <= motor_d != SPD_OFF;
            done <= state_d == S_DONE;
            alarm <= state_d == S_FAULT || reject;
        end
    end
endmodule

// File: tb/tb_wash_program_sequencer.sv
// tb_wash_program_sequencer: directed and random stimulus against a phase/duration model of the sequencer.
module tb_wash_program_sequencer;
    localparam int TW = 16, WT = 4, RT = 3, ST = 5, DT = 6, NP = 2, FT = 8;
    localparam int IDLE = 0, FILL = 1, WASH = 2, DRAIN = 3, RFILL = 4, RINSE = 5, RDRAIN = 6;
    localparam int SPIN = 7, DRY = 8, DONE = 9, PAUSED = 10, ABORT = 11, FAULT = 12;
    localparam logic [12:0] LOCK_M  = 13'b0_1101_1111_1110;
    localparam logic [12:0] FILL_M  = 13'b0_0000_0001_0010;
    localparam logic [12:0] DRAIN_M = 13'b0_1000_1100_1000;
    localparam logic [12:0] LOW_M   = 13'b0_0001_0010_0100;

    logic clk = 0, rst = 1, start = 0, stop = 0, pause = 0, doorclosed = 1, detergentfilled = 1;
    logic water_full = 0, water_empty = 0, washOnly = 0, dry = 0;
    logic [1:0] waterTemp = 0, spinSpeed = 0;
    logic doorLock, fill_value_on, drain_value_on, soap_value_on, motorStart, done, alarm;
    logic [1:0] heater_on, motor_speed;
    logic [3:0] state;
    logic [2:0] rinse_count;
    logic [TW-1:0] timer;

    int n_cmp = 0, n_bad = 0;
    int full_dly = 2, empty_dly = 1, fc = 0, dc = 0;
    bit plant = 1;

    always #5 clk = ~clk;

    wash_program_sequencer #(
        .TIMER_W(TW), .WASH_TICKS(WT), .RINSE_TICKS(RT), .SPIN_TICKS(ST),
        .DRY_TICKS(DT), .RINSE_PASSES(NP), .FILL_TIMEOUT(FT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .doorclosed(doorclosed), .detergentfilled(detergentfilled),
        .water_full(water_full), .water_empty(water_empty), .washOnly(washOnly), .dry(dry),
        .waterTemp(waterTemp), .spinSpeed(spinSpeed), .doorLock(doorLock),
        .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
        .soap_value_on(soap_value_on), .motorStart(motorStart), .heater_on(heater_on),
        .motor_speed(motor_speed), .state(state), .rinse_count(rinse_count), .timer(timer),
        .done(done), .alarm(alarm)
    );

    // Model: current phase, its duration and cycles elapsed in it; timer = duration - elapsed.
    int dur [13] = '{0, FT, WT, 0, FT, RT, 0, ST, DT, 0, 0, 0, 0};
    int m_st = 0, m_ret = 0, m_el = 0, m_dur = 0, m_rc = 0;
    bit m_wo = 0, m_dry = 0, m_rej = 0;
    logic [1:0] m_temp = 0, m_spd = 0;

    always @(posedge clk or posedge rst) begin : model
        int nx;
        bit run, hold;
        if (rst) begin
            m_st = IDLE; m_ret = IDLE; m_el = 0; m_dur = 0; m_rc = 0;
            m_wo = 0; m_dry = 0; m_rej = 0; m_temp = 0; m_spd = 0;
        end else begin
            run = m_st >= FILL && m_st <= DRY;
            nx = m_st;
            hold = 0;
            m_rej = 0;
            if (stop && m_st != ABORT) nx = (run || m_st == PAUSED) ? ABORT : IDLE;
            else if (!doorclosed && (run || m_st == PAUSED)) nx = FAULT;
            else if ((m_st == FILL || m_st == RFILL) && m_el == m_dur - 1 && !water_full) nx = FAULT;
            else if (pause && run) begin nx = PAUSED; m_ret = m_st; hold = 1; end
            else if (m_st == PAUSED) begin if (!pause) begin nx = m_ret; hold = 1; end end
            else if (m_st == IDLE) begin
                if (start && doorclosed && detergentfilled) begin
                    nx = FILL; m_rc = 0;
                    m_wo = washOnly; m_dry = dry; m_temp = waterTemp; m_spd = spinSpeed;
                end else m_rej = start;
            end
            else if (m_st == DONE) nx = IDLE;
            else if (m_st == ABORT) begin if (water_empty) nx = IDLE; end
            else if (m_st == DRAIN) begin if (water_empty) nx = m_wo ? DONE : RFILL; end
            else if (m_st == RDRAIN) begin
                if (water_empty) begin m_rc++; nx = (m_rc == NP) ? SPIN : RFILL; end
            end
            else if (m_st == FILL || m_st == RFILL) begin if (water_full) nx = m_st + 1; end
            else if (m_st != FAULT && m_el == m_dur - 1)
                nx = (m_st == WASH) ? DRAIN : (m_st == RINSE) ? RDRAIN : (m_st == SPIN && m_dry) ? DRY : DONE;
            if (!hold) begin
                if (nx != m_st) begin m_dur = dur[nx]; m_el = 0; end
                else if (m_dur != 0 && m_st != PAUSED) m_el++;
            end
            m_st = nx;
        end
    end

    function automatic logic [33:0] exp_vec();
        logic [1:0] mot;
        mot = LOW_M[m_st] ? 2'd1 : (m_st == SPIN) ? ((m_spd == 2'd0) ? 2'd1 : m_spd) : 2'd0;
        return {4'(m_st), 16'(m_dur - m_el), 3'(m_rc), LOCK_M[m_st], FILL_M[m_st], DRAIN_M[m_st],
                m_st == FILL, mot != 2'd0, (m_st == WASH) ? m_temp : 2'd0, mot, m_st == DONE,
                m_st == FAULT || m_rej};
    endfunction

    function automatic logic [33:0] act_vec();
        return {state, timer, rinse_count, doorLock, fill_value_on, drain_value_on, soap_value_on,
                motorStart, heater_on, motor_speed, done, alarm};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    // One cycle: compare every output to the model at the falling edge, then advance past the
    // rising edge and update the simple tub model driving the level sensors.
    task automatic step();
        @(negedge clk);
        chk("cycle_outputs", 64'(act_vec()), 64'(exp_vec()));
        @(posedge clk);
        #2;
        fc = fill_value_on ? fc + 1 : 0;
        dc = drain_value_on ? dc + 1 : 0;
        if (plant) begin
            water_full = fc >= full_dly;
            water_empty = dc >= empty_dly;
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        for (int i = 0; i < budget && int'(state) != s; i++) step();
        chk(nm, 64'(state), 64'(s));
    endtask

    task automatic start_prog(input logic wo, input logic dr, input logic [1:0] t, input logic [1:0] s);
        washOnly = wo; dry = dr; waterTemp = t; spinSpeed = s;
        doorclosed = 1; detergentfilled = 1; start = 1;
        step();
        start = 0;
        chk("start_accept", 64'(state), FILL);
    endtask

    initial begin
        logic [63:0] path;
        logic [15:0] seen;
        logic [3:0] prev;
        int n, spin_n, done_n;
        logic [2:0] rc_at;
        logic lock_at;
        step();
        step();
        rst = 0;
        chk("rst_state", 64'(state), IDLE);
        chk("rst_timer", 64'(timer), 0);
        chk("rst_outputs", 64'(act_vec()), 0);

        // rejected start
        detergentfilled = 0; start = 1;
        step();
        start = 0; detergentfilled = 1;
        chk("reject_state", 64'(state), IDLE);
        chk("reject_alarm", 64'(alarm), 1);
        step();
        chk("reject_alarm_clear", 64'(alarm), 0);

        // full program with two rinses
        start_prog(0, 0, 2'd2, 2'd3);
        path = 64'(FILL); prev = 4'(FILL); spin_n = 0; done_n = 0; rc_at = 0; lock_at = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (state != prev) begin path = (path << 4) | 64'(state); prev = state; end
            if (int'(state) == SPIN) spin_n++;
            if (done) begin done_n++; rc_at = rinse_count; lock_at = doorLock; end
            if (int'(state) == IDLE) break;
        end
        chk("full_path", path, 64'h123456456790);
        chk("full_spin_cycles", 64'(spin_n), 5);
        chk("full_done_pulses", 64'(done_n), 1);
        chk("full_rinse_count", 64'(rc_at), 2);
        chk("full_done_doorlock", 64'(lock_at), 0);

        // washOnly wins over dry
        start_prog(1, 1, 2'd1, 2'd1);
        seen = 0;
        for (int i = 0; i < 100 && int'(state) != IDLE; i++) begin seen[state] = 1'b1; step(); end
        chk("washonly_skips", 64'(seen & 16'h0190), 0);
        chk("washonly_done", 64'(seen[DONE]), 1);

        // pause mid-WASH with two cycles left
        start_prog(0, 0, 2'd3, 2'd0);
        for (int i = 0; i < 50 && !(int'(state) == WASH && timer == 2); i++) step();
        chk("pause_reach_wash", 64'(state), WASH);
        pause = 1;
        repeat (10) step();
        chk("pause_state", 64'(state), PAUSED);
        chk("pause_timer", 64'(timer), 2);
        chk("pause_motor", 64'(motor_speed), 0);
        chk("pause_doorlock", 64'(doorLock), 1);
        pause = 0;
        step();
        n = 0;
        while (int'(state) == WASH && n < 20) begin n++; step(); end
        chk("pause_resume_cycles", 64'(n), 2);
        wait_state(IDLE, 200, "pause_end");

        // fill timeout
        full_dly = 1000;
        start_prog(0, 0, 2'd0, 2'd0);
        n = 0;
        while (int'(state) == FILL && n < 20) begin n++; step(); end
        chk("fault_fill_cycles", 64'(n), 8);
        chk("fault_state", 64'(state), FAULT);
        repeat (3) step();
        chk("fault_alarm_held", 64'(alarm), 1);
        stop = 1;
        step();
        stop = 0;
        full_dly = 2;
        chk("fault_stop_state", 64'(state), IDLE);
        chk("fault_stop_alarm", 64'(alarm), 0);

        // stop during RINSE, slow drain
        empty_dly = 5;
        start_prog(0, 0, 2'd1, 2'd2);
        wait_state(RINSE, 100, "abort_reach_rinse");
        stop = 1;
        step();
        stop = 0;
        chk("abort_state", 64'(state), ABORT);
        chk("abort_drain", 64'(drain_value_on), 1);
        chk("abort_doorlock", 64'(doorLock), 1);
        n = 0;
        while (int'(state) == ABORT && n < 20) begin n++; step(); end
        chk("abort_cycles", 64'(n), 5);
        chk("abort_idle", 64'(state), IDLE);
        empty_dly = 1;

        // reset mid-SPIN
        start_prog(0, 1, 2'd3, 2'd2);
        wait_state(SPIN, 100, "rst_reach_spin");
        rst = 1;
        #1;
        chk("rst_spin_outputs", 64'(act_vec()), 0);
        step();
        rst = 0;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                full_dly = $urandom_range(0, 4);
                empty_dly = $urandom_range(0, 4);
                plant = $urandom_range(0, 3) != 0;
            end
            if (!plant) begin water_full = $urandom_range(0, 3) == 0; water_empty = $urandom_range(0, 3) == 0; end
            start = $urandom_range(0, 7) == 0;
            stop = $urandom_range(0, 59) == 0;
            if ($urandom_range(0, 19) == 0) pause = ~pause;
            doorclosed = $urandom_range(0, 149) != 0;
            detergentfilled = $urandom_range(0, 9) != 0;
            washOnly = 1'($urandom); dry = 1'($urandom);
            waterTemp = 2'($urandom); spinSpeed = 2'($urandom);
            rst = $urandom_range(0, 999) == 0;
            step();
        end
        rst = 0; start = 0; stop = 0; pause = 0; doorclosed = 1;
        step();
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end
endmodule
